cla_pipe_adder: RTL and testbench
=================================

// Module: cla_pipe_adder
// PURPOSE
//  Parametrised, block-pipelined carry-lookahead adder/subtractor with valid/ready flow control.
//  Splits WIDTH into NBLK = WIDTH/BLOCK lookahead blocks and resolves one block per pipeline stage.
//  Carry is registered between stages; operands are skewed so that throughput is 1 op/cycle.
//  Datapath arithmetic core for the accumulator/ALU tiles; it replaces single-cycle wide adders.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; must be a multiple of BLOCK (elaboration error otherwise)
//  BLOCK  8   bits per lookahead block and per pipeline stage; 2..16
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block accepts operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  carry_in   in   1      carry into bit 0 (ADD only)
//  mode       in   1      0 = ADD (a+b+carry_in), 1 = SUB (a-b)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  carry_out  out  1      carry from the MSB (SUB: 1 = no borrow)
//  overflow   out  1      signed overflow = carry into MSB ^ carry out of MSB
//  blk_pg     out  2*NBLK per-block {G,P} of the result op; used for debug and lookahead chaining
// BEHAVIOUR
//  - Per bit: p = a^b', g = a&b', sum = p^c, where b' = mode ? ~b : b. Per block: P = &p, G = lookahead of g/p.
//  - Effective carry into block 0: mode ? 1 : carry_in. Block k carry-out = G | (P & cin_k).
//  - Stage k (0..NBLK-1) computes block k from the registered carry of stage k-1; upper operand
//    slices and mode travel with the op; lower result slices travel forward. Latency = NBLK cycles.
//  - Global-advance pipeline: adv = ~out_valid | out_ready; in_ready = adv. When adv = 0, every stage
//    holds. A transfer occurs on in_valid & in_ready. Bubbles propagate as valid = 0 stages.
//  - Outputs are held stable while out_valid & ~out_ready, and change only on adv.
//  - in_valid = 0 with adv = 1 inserts a bubble; back-to-back ops with mixed mode are independent.
//  - Reset (any time, including mid-stream): all stage valids = 0, carries = 0; out_valid = 0,
//    sum = 0, carry_out = 0, overflow = 0, blk_pg = 0, in_ready = 1 after rst deasserts. In-flight ops are lost.
//  - Wrap-around: results are modulo 2^WIDTH unless saturation is compiled in.
// CONFIGURATION
//  CLA_PIPE_SAT_EN defined: if overflow = 1, sum is clamped to the signed max (0x7F..F) when the
//   true result is positive, and to the signed min (0x80..0) when it is negative. overflow and
//   carry_out still report the raw values. This adds one mux at the final stage; latency is unchanged.
//  Not defined: sum wraps, and no clamp logic is built.
// STRUCTURE
//  Package cla_pkg: typedef enum {CLA_ADD=1'b0, CLA_SUB=1'b1} cla_mode_e; function cla_nblk(WIDTH,BLOCK).
//  Sub-module cla_block #(BLOCK): combinational BLOCK-bit lookahead with inputs a, b, cin and
//   outputs sum, P, G, cout, c_msb (carry into the top bit). One instance per stage via generate.
//  Top: generate loop of NBLK stage registers + skew registers + handshake + optional clamp.
// TESTING (WIDTH=32, BLOCK=8, latency 4)
//  1. ADD 0xFFFF_FFFF + 0x0000_0001, cin=0 -> after 4 cycles sum=0, carry_out=1, overflow=0; blk_pg all P=1 except block0 G=1.
//  2. SUB 0x8000_0000 - 0x0000_0001 -> sum=0x7FFF_FFFF, carry_out=1, overflow=1; with CLA_PIPE_SAT_EN sum=0x8000_0000.
//  3. ADD 0x7FFF_FFFF + 1 -> overflow=1; sum=0x8000_0000 (no SAT) or 0x7FFF_FFFF (SAT).
//  4. Stream 8 back-to-back random ops with out_ready toggling every 3 cycles -> results in order,
//     match the reference model, no drops/dups, outputs stable while stalled, in_ready = adv.
//  5. Assert rst while 3 ops are in flight -> out_valid=0 next edge, no stale result after release.
//  6. Sweep BLOCK=4 and BLOCK=16 with WIDTH=32 (latency 8/2) plus 10k random ADD/SUB -> zero mismatches.

Source files
------------

// File: rtl/cla_pkg.sv
// Shared types and helpers for the block-pipelined carry-lookahead adder.
//   cla_mode_e : operation select (ADD = a+b+carry_in, SUB = a-b)
//   cla_nblk   : number of lookahead blocks (= pipeline stages) for a width/block pair
package cla_pkg;

    typedef enum logic {
        CLA_ADD = 1'b0,
        CLA_SUB = 1'b1
    } cla_mode_e;

    function automatic int cla_nblk(input int width, input int block);
        return width / block;
    endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead slice.
// Ports:
//   a_i, b_i  : block operands (b_i already inverted by the caller for SUB)
//   cin_i     : carry into bit 0 of the block
//   sum_o     : block sum
//   p_o, g_o  : block propagate / generate
//   cout_o    : carry out of the block MSB
//   c_msb_o   : carry into the block MSB (used for signed overflow on the top block)
module cla_block #(
    parameter int BLOCK = 8
) (
    input  logic [BLOCK-1:0] a_i,
    input  logic [BLOCK-1:0] b_i,
    input  logic             cin_i,
    output logic [BLOCK-1:0] sum_o,
    output logic             p_o,
    output logic             g_o,
    output logic             cout_o,
    output logic             c_msb_o
);

    logic [BLOCK-1:0] p;
    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] c;
    logic             grp_g;
    logic             grp_p;

    // Each bit carry is formed from the group G/P of all lower bits and cin,
    // so no carry depends on the previous bit's carry signal.
    always_comb begin
        p     = a_i ^ b_i;
        g     = a_i & b_i;
        c     = '0;
        grp_g = 1'b0;
        grp_p = 1'b1;
        for (int i = 0; i < BLOCK; i++) begin
            c[i]  = grp_g | (grp_p & cin_i);
            grp_g = g[i] | (p[i] & grp_g);
            grp_p = grp_p & p[i];
        end
    end

    assign sum_o   = p ^ c;
    assign p_o     = grp_p;
    assign g_o     = grp_g;
    assign cout_o  = grp_g | (grp_p & cin_i);
    assign c_msb_o = c[BLOCK-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Block-pipelined carry-lookahead adder/subtractor with valid/ready flow control.
// One lookahead block is resolved per stage; the block carry is registered between
// stages, unused upper operand slices ride along and finished lower sum slices are
// carried forward, giving NBLK cycles of latency at one op per cycle.
//
// Ports:
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid / in_ready  : operand handshake (in_ready = global advance)
//   a, b, carry_in, mode : operands; mode 0 = a+b+carry_in, 1 = a-b
//   out_valid / out_ready: result handshake
//   sum, carry_out       : result and carry from the MSB (SUB: 1 = no borrow)
//   overflow             : signed overflow (carry into MSB ^ carry out of MSB)
//   blk_pg               : per-block {G,P}; block k at [2k+1:2k], G in the upper bit
//
// Build option:
//   CLA_PIPE_SAT_EN : clamp sum to the signed max/min on overflow
//                     (overflow and carry_out still report the raw values)
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int BLOCK = 8,
    localparam int NBLK  = cla_nblk(WIDTH, BLOCK)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              carry_in,
    input  logic              mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  sum,
    output logic              carry_out,
    output logic              overflow,
    output logic [2*NBLK-1:0] blk_pg
);

    if ((WIDTH % BLOCK) != 0 || BLOCK < 2 || BLOCK > 16) begin : g_param_check
        $error("cla_pipe_adder: WIDTH must be a multiple of BLOCK and BLOCK must be 2..16");
    end

    logic             adv;
    logic [WIDTH-1:0] b_eff;
    logic             cin0;
    logic             ovf_d;
    logic             ovf_q;
    logic [WIDTH-1:0] res_w;

    // Every stage moves together; a stalled output freezes the whole pipe.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Subtraction is a + ~b + 1, so only the inverted b needs to travel with the op.
    assign b_eff = (cla_mode_e'(mode) == CLA_SUB) ? ~b : b;
    assign cin0  = (cla_mode_e'(mode) == CLA_SUB) ? 1'b1 : carry_in;

    for (genvar k = 0; k < NBLK; k++) begin : g_stg
        localparam int REM = WIDTH - k*BLOCK;   // operand bits still unresolved at this stage

        logic [REM-1:0]         op_a;
        logic [REM-1:0]         op_b;
        logic                   blk_cin;
        logic                   v_in;
        logic [BLOCK-1:0]       blk_sum;
        logic                   blk_p;
        logic                   blk_g;
        logic                   blk_cout;
        logic                   blk_cmsb;
        logic [(k+1)*BLOCK-1:0] res_d;
        logic [(k+1)*BLOCK-1:0] res_q;
        logic [2*k+1:0]         pg_d;
        logic [2*k+1:0]         pg_q;
        logic                   valid_q;
        logic                   carry_q;

        cla_block #(.BLOCK(BLOCK)) u_blk (
            .a_i     (op_a[BLOCK-1:0]),
            .b_i     (op_b[BLOCK-1:0]),
            .cin_i   (blk_cin),
            .sum_o   (blk_sum),
            .p_o     (blk_p),
            .g_o     (blk_g),
            .cout_o  (blk_cout),
            .c_msb_o (blk_cmsb)
        );

        if (k == 0) begin : g_src
            assign op_a    = a;
            assign op_b    = b_eff;
            assign blk_cin = cin0;
            assign v_in    = in_valid;
            assign res_d   = blk_sum;
            assign pg_d    = {blk_g, blk_p};
        end else begin : g_src
            assign op_a    = g_stg[k-1].g_fwd.a_up_q;
            assign op_b    = g_stg[k-1].g_fwd.b_up_q;
            assign blk_cin = g_stg[k-1].carry_q;
            assign v_in    = g_stg[k-1].valid_q;
            assign res_d   = {blk_sum, g_stg[k-1].res_q};
            assign pg_d    = {blk_g, blk_p, g_stg[k-1].pg_q};
        end

        // Upper operand slices are only needed while blocks remain above this one.
        if (k < NBLK-1) begin : g_fwd
            logic [REM-BLOCK-1:0] a_up_q;
            logic [REM-BLOCK-1:0] b_up_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_up_q <= '0;
                    b_up_q <= '0;
                end else if (adv) begin
                    a_up_q <= op_a[REM-1:BLOCK];
                    b_up_q <= op_b[REM-1:BLOCK];
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                res_q   <= '0;
                pg_q    <= '0;
            end else if (adv) begin
                valid_q <= v_in;
                carry_q <= blk_cout;
                res_q   <= res_d;
                pg_q    <= pg_d;
            end
        end
    end

    assign ovf_d = g_stg[NBLK-1].blk_cmsb ^ g_stg[NBLK-1].blk_cout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= ovf_d;
        end
    end

    assign out_valid = g_stg[NBLK-1].valid_q;
    assign carry_out = g_stg[NBLK-1].carry_q;
    assign blk_pg    = g_stg[NBLK-1].pg_q;
    assign overflow  = ovf_q;
    assign res_w     = g_stg[NBLK-1].res_q;

`ifdef CLA_PIPE_SAT_EN
    // On signed overflow the operands share a sign, so the true sign of the
    // (WIDTH+1)-bit result equals carry_out: 1 -> negative, 0 -> positive.
    assign sum = ovf_q ? (carry_out ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                       : res_w;
`else
    assign sum = res_w;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
module tb_cla_pipe_adder;
    import cla_pkg::*;

    localparam int W        = 32;
    parameter  int TB_BLOCK = 8;
    localparam int NB       = W / TB_BLOCK;

    typedef struct packed {
        logic [W-1:0]    sum;
        logic            cout;
        logic            ovf;
        logic [2*NB-1:0] pg;
    } res_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [W-1:0]    a;
    logic [W-1:0]    b;
    logic            carry_in;
    logic            mode;
    logic            out_valid;
    logic            out_ready = 1'b1;
    logic [W-1:0]    sum;
    logic            carry_out;
    logic            overflow;
    logic [2*NB-1:0] blk_pg;

    cla_pipe_adder #(.WIDTH(W), .BLOCK(TB_BLOCK)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow),
        .blk_pg    (blk_pg)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    int   n_acc  = 0;
    int   n_out  = 0;
    int   n_lost = 0;
    int   cyc    = 0;
    int   rdy_mode = 0;
    res_t exp_q[$];

`ifdef CLA_PIPE_SAT_EN
    localparam logic [W-1:0] T2_SUM = 32'h8000_0000;
    localparam logic [W-1:0] T3_SUM = 32'h7FFF_FFFF;
`else
    localparam logic [W-1:0] T2_SUM = 32'h7FFF_FFFF;
    localparam logic [W-1:0] T3_SUM = 32'h8000_0000;
`endif

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference: plain integer arithmetic on the whole word, per-block G/P from slice sums.
    function automatic res_t model(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                   input logic rcin, input logic rm);
        res_t r;
        logic [W:0] raw;
        longint sa, sb, tr, smax, smin;
        logic [TB_BLOCK-1:0] ab, bb;
        logic [TB_BLOCK:0]   t;
        if (rm) raw = {1'b0, ra} + {1'b0, ~rb} + 33'd1;
        else    raw = {1'b0, ra} + {1'b0, rb} + {32'd0, rcin};
        sa   = longint'($signed(ra));
        sb   = longint'($signed(rb));
        tr   = rm ? (sa - sb) : (sa + sb + longint'(rcin));
        smax = (longint'(1) <<< (W-1)) - 1;
        smin = -(longint'(1) <<< (W-1));
        r.sum  = raw[W-1:0];
        r.cout = raw[W];
        r.ovf  = (tr > smax) || (tr < smin);
`ifdef CLA_PIPE_SAT_EN
        if (r.ovf) r.sum = (tr > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
`endif
        r.pg = '0;
        for (int k = 0; k < NB; k++) begin
            ab = ra[k*TB_BLOCK +: TB_BLOCK];
            bb = rm ? ~rb[k*TB_BLOCK +: TB_BLOCK] : rb[k*TB_BLOCK +: TB_BLOCK];
            t  = {1'b0, ab} + {1'b0, bb};
            r.pg[2*k+1] = t[TB_BLOCK];
            r.pg[2*k]   = &(ab ^ bb);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        #1;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ((cyc / 3) % 2) == 0;
            2:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Scoreboard: every cycle with a valid result is compared against the oldest
    // outstanding model result, which also covers hold-stability during stalls.
    always @(negedge clk) begin
        if (rst) begin
            n_lost += exp_q.size();
            exp_q.delete();
        end else begin
            chk("in_ready_eq_adv", 128'(in_ready), 128'(!out_valid || out_ready));
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out_valid", 128'(out_valid), 128'(0));
                end else begin
                    chk("result", 128'({sum, carry_out, overflow, blk_pg}), 128'(exp_q[0]));
                    if (out_ready) begin
                        void'(exp_q.pop_front());
                        n_out++;
                    end
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(a, b, carry_in, mode));
                n_acc++;
            end
        end
    end

    task automatic issue(input logic [W-1:0] ia, input logic [W-1:0] ib,
                         input logic icin, input logic im);
        logic acc;
        logic ok;
        a = ia; b = ib; carry_in = icin; mode = im; in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #2;
            if (acc) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        if (!ok) chk("issue_accept", 128'(ok), 128'(1));
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    // Issue a single op into an empty pipe and stop at the negedge where it appears.
    task automatic directed(input string name, input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic icin, input logic im, input logic [W-1:0] esum,
                            input logic ecout, input logic eovf);
        int   lat;
        logic found;
        rdy_mode = 0;
        issue(ia, ib, icin, im);
        lat   = 0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk({name, "_seen"}, 128'(found), 128'(1));
        chk({name, "_latency"}, 128'(lat), 128'(NB));
        chk({name, "_sum"}, 128'(sum), 128'(esum));
        chk({name, "_cout"}, 128'(carry_out), 128'(ecout));
        chk({name, "_ovf"}, 128'(overflow), 128'(eovf));
    endtask

    task automatic drain();
        for (int i = 0; i < 500; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #2;
        end
        chk("drain_empty", 128'(exp_q.size()), 128'(0));
    endtask

    function automatic logic [W-1:0] rnd_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            4:       return 32'h0000_0001;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2*NB-1:0] pg1;
        int              seen;

        rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; mode = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", 128'(out_valid), 128'(0));
        chk("rst_sum", 128'(sum), 128'(0));
        chk("rst_cout", 128'(carry_out), 128'(0));
        chk("rst_ovf", 128'(overflow), 128'(0));
        chk("rst_pg", 128'(blk_pg), 128'(0));
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 128'(in_ready), 128'(1));

        // Test 1: all-ones + 1
        directed("t1_add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, CLA_ADD, 32'h0, 1'b1, 1'b0);
        pg1 = '0;
        for (int k = 0; k < NB; k++) pg1[2*k +: 2] = (k == 0) ? 2'b10 : 2'b01;
        chk("t1_blk_pg", 128'(blk_pg), 128'(pg1));
        idle(1);

        // Test 2: signed min - 1
        directed("t2_sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, CLA_SUB, T2_SUM, 1'b1, 1'b1);
        idle(1);

        // Test 3: signed max + 1
        directed("t3_add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, CLA_ADD, T3_SUM, 1'b0, 1'b1);
        idle(1);

        // Additional pins: carry_in path and borrow
        directed("t_cin", 32'h0000_00FF, 32'h0000_0000, 1'b1, CLA_ADD, 32'h0000_0100, 1'b0, 1'b0);
        idle(1);
        directed("t_borrow", 32'h0000_0001, 32'h0000_0002, 1'b1, CLA_SUB, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(1);

        // Test 4: 8 back-to-back ops with out_ready toggling every 3 cycles
        rdy_mode = 1;
        for (int i = 0; i < 8; i++) issue($urandom, $urandom, 1'($urandom), 1'($urandom));
        drain();
        rdy_mode = 0;
        idle(2);

        // Test 5: reset with ops in flight and a stalled result on the output
        for (int i = 0; i < 3; i++) issue(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
        rdy_mode = 3;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_out_valid", 128'(out_valid), 128'(0));
        chk("t5_sum", 128'(sum), 128'(0));
        chk("t5_pg", 128'(blk_pg), 128'(0));
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        rdy_mode = 0;
        #1;
        chk("t5_in_ready", 128'(in_ready), 128'(1));
        seen = 0;
        for (int i = 0; i < NB + 4; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("t5_no_stale", 128'(seen), 128'(0));
        @(posedge clk);
        #2;

        // Test 6: random stream with bubbles and random backpressure
        rdy_mode = 2;
        for (int i = 0; i < 10000; i++) begin
            if ($urandom_range(0, 4) == 0) idle(1);
            issue(rnd_op(), rnd_op(), 1'($urandom), 1'($urandom));
        end
        rdy_mode = 0;
        drain();
        chk("op_count", 128'(n_out), 128'(n_acc - n_lost));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
